// File: rtl/operand_req_arbiter.sv
// Credit-limited round-robin arbiter sharing one VRF read port among NrReq operand queues.
// Optional ARA_OPQ_ARB_PERF_EN adds stall_cnt_o, a saturating count of request-without-grant cycles.
//   state | meaning
//   IDLE  | ready for a new command
//   CMD   | pushing the command into the queue's command FIFO
//   ISSUE | competing for VRF reads until remaining words reach 0
module operand_req_arbiter #(
    parameter int unsigned NrReq       = 4,
    parameter int unsigned BufferDepth = 2,
    parameter int unsigned CntWidth    = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NrReq-1:0]                 req_valid_i,
    input  logic [NrReq-1:0][CntWidth-1:0]   req_nwords_i,
    output logic [NrReq-1:0]                 req_ready_o,
    output logic [NrReq-1:0]                 cmd_valid_o,
    output logic                             vrf_req_o,
    output logic [$clog2(NrReq)-1:0]         vrf_idx_o,
    input  logic                             vrf_gnt_i,
    output logic [NrReq-1:0]                 issued_o,
    input  logic [NrReq-1:0]                 pop_i,
    output logic                             busy_o,
    output logic                             err_o
`ifdef ARA_OPQ_ARB_PERF_EN
    ,
    output logic [31:0]                      stall_cnt_o
`endif
);

    localparam int unsigned IdxW  = $clog2(NrReq);
    localparam int unsigned UsedW = $clog2(BufferDepth + 1);

    typedef enum logic [1:0] {IDLE, CMD, ISSUE} state_e;

    state_e              state_q [NrReq];
    state_e              state_d [NrReq];
    logic [CntWidth-1:0] rem_q   [NrReq];
    logic [UsedW-1:0]    used_q  [NrReq];
    logic [IdxW-1:0]     rr_q;
    logic [IdxW-1:0]     winner;
    logic [IdxW-1:0]     cand;
    logic                found;
    logic [NrReq-1:0]    eligible;
    logic [NrReq-1:0]    underflow;
    logic                grant;
    logic                err_q;

    always_comb begin
        eligible  = '0;
        underflow = '0;
        for (int i = 0; i < NrReq; i++) begin
            eligible[i]  = (state_q[i] == ISSUE) && (rem_q[i] != '0) &&
                           (used_q[i] < UsedW'(BufferDepth));
            underflow[i] = pop_i[i] && (used_q[i] == '0);
        end
    end

    // First eligible requester at or after rr_q, wrapping.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 0; k < NrReq; k++) begin
            cand = IdxW'((int'(rr_q) + k) % NrReq);
            if (!found && eligible[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign grant = found && vrf_gnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrReq; i++) state_q[i] <= IDLE;
        end else begin
            for (int i = 0; i < NrReq; i++) state_q[i] <= state_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NrReq; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:    if (req_valid_i[i]) state_d[i] = CMD;
                CMD:     state_d[i] = (rem_q[i] == '0) ? IDLE : ISSUE;
                ISSUE:   if (grant && (winner == IdxW'(i)) && (rem_q[i] == CntWidth'(1)))
                             state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready_o = '0;
        cmd_valid_o = '0;
        issued_o    = '0;
        busy_o      = 1'b0;
        for (int i = 0; i < NrReq; i++) begin
            req_ready_o[i] = (state_q[i] == IDLE);
            cmd_valid_o[i] = (state_q[i] == CMD);
            issued_o[i]    = grant && (winner == IdxW'(i));
            if (state_q[i] != IDLE) busy_o = 1'b1;
        end
        vrf_req_o = found;
        vrf_idx_o = winner;
        err_o     = err_q;
    end

    // A pop against an empty buffer is not counted; an issue in the same cycle still counts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrReq; i++) begin
                rem_q[i]  <= '0;
                used_q[i] <= '0;
            end
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NrReq; i++) begin
                if (req_ready_o[i] && req_valid_i[i]) rem_q[i] <= req_nwords_i[i];
                else if (issued_o[i])                 rem_q[i] <= rem_q[i] - CntWidth'(1);
                case ({issued_o[i], pop_i[i] && !underflow[i]})
                    2'b10:   used_q[i] <= used_q[i] + UsedW'(1);
                    2'b01:   used_q[i] <= used_q[i] - UsedW'(1);
                    default: used_q[i] <= used_q[i];
                endcase
            end
            if (grant) rr_q <= (winner == IdxW'(NrReq - 1)) ? '0 : winner + IdxW'(1);
            if (|underflow) err_q <= 1'b1;
        end
    end

`ifdef ARA_OPQ_ARB_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                       stall_cnt_o <= '0;
        else if (found && !vrf_gnt_i && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_operand_req_arbiter.sv
// Randomized and directed bench for operand_req_arbiter; a queue-based reference model predicts
// per-cycle status, command pushes and grant order, and a monitor checks them against the DUT.
module tb_operand_req_arbiter;
    localparam int NR = 4;
    localparam int BD = 2;
    localparam int CW = 16;
    localparam int IW = $clog2(NR);

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic [NR-1:0]         req_valid_i;
    logic [NR-1:0][CW-1:0] req_nwords_i;
    logic [NR-1:0]         req_ready_o;
    logic [NR-1:0]         cmd_valid_o;
    logic                  vrf_req_o;
    logic [IW-1:0]         vrf_idx_o;
    logic                  vrf_gnt_i;
    logic [NR-1:0]         issued_o;
    logic [NR-1:0]         pop_i;
    logic                  busy_o;
    logic                  err_o;
`ifdef ARA_OPQ_ARB_PERF_EN
    logic [31:0]           stall_cnt_o;
`endif

    operand_req_arbiter #(.NrReq(NR), .BufferDepth(BD), .CntWidth(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_nwords_i(req_nwords_i),
        .req_ready_o(req_ready_o), .cmd_valid_o(cmd_valid_o), .vrf_req_o(vrf_req_o),
        .vrf_idx_o(vrf_idx_o), .vrf_gnt_i(vrf_gnt_i), .issued_o(issued_o), .pop_i(pop_i),
        .busy_o(busy_o), .err_o(err_o)
`ifdef ARA_OPQ_ARB_PERF_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [NR-1:0] ready;
        logic          busy;
        logic          vreq;
        logic [IW-1:0] idx;
        logic          err;
    } stat_t;

    stat_t         stat_q[$];
    logic [NR-1:0] cmd_q[$];
    int            issue_q[$];
    int            total = 0;
    int            bad = 0;

    // Reference model: a requester is "active" from acceptance until its last word is granted
    // (or until its command pulse when it carries no words).
    bit m_active[NR], m_announce[NR];
    int m_rem[NR], m_used[NR], m_rr;
    bit m_err;

    logic [NR-1:0] d_valid, d_pop;
    int            d_nw[NR];
    logic          d_gnt;

    int obs_order[$], obs_cyc[$], obs_cmd, cmd_cyc, cyc = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_active[i] = 0; m_announce[i] = 0; m_rem[i] = 0; m_used[i] = 0;
        end
        m_rr = 0; m_err = 0;
        stat_q.delete(); cmd_q.delete(); issue_q.delete();
    endtask

    task automatic clear_obs();
        obs_order.delete(); obs_cyc.delete(); obs_cmd = 0; cmd_cyc = -1;
    endtask

    task automatic idle_drive();
        d_valid = '0; d_pop = '0; d_gnt = 1'b0;
        for (int i = 0; i < NR; i++) d_nw[i] = 0;
    endtask

    task automatic step();
        stat_t e;
        logic [NR-1:0] ec;
        bit any, iss, was_idle[NR];
        int w, j, ub[NR];
        @(negedge clk_i);
        req_valid_i = d_valid; vrf_gnt_i = d_gnt; pop_i = d_pop;
        for (int i = 0; i < NR; i++) req_nwords_i[i] = CW'(d_nw[i]);
        #1;
        any = 0; w = 0;
        for (int k = 0; k < NR; k++) begin
            j = (m_rr + k) % NR;
            if (!any && m_active[j] && !m_announce[j] && m_rem[j] > 0 && m_used[j] < BD) begin
                any = 1; w = j;
            end
        end
        e = '0; ec = '0;
        for (int i = 0; i < NR; i++) begin
            e.ready[i] = !m_active[i];
            ec[i] = m_announce[i];
            if (m_active[i]) e.busy = 1'b1;
        end
        e.vreq = any; e.idx = IW'(w); e.err = m_err;
        iss = any && d_gnt;
        stat_q.push_back(e);
        if (ec != '0) cmd_q.push_back(ec);
        if (iss) issue_q.push_back(w);
        for (int i = 0; i < NR; i++) begin
            was_idle[i] = !m_active[i];
            ub[i] = m_used[i];
            if (m_announce[i]) begin
                m_announce[i] = 0;
                if (m_rem[i] == 0) m_active[i] = 0;
            end
        end
        if (iss) begin
            m_rem[w]--; m_used[w]++;
            if (m_rem[w] == 0) m_active[w] = 0;
            m_rr = (w + 1) % NR;
        end
        for (int i = 0; i < NR; i++) begin
            if (d_pop[i]) begin
                if (ub[i] == 0) m_err = 1;
                else m_used[i]--;
            end
            if (was_idle[i] && d_valid[i]) begin
                m_active[i] = 1; m_announce[i] = 1; m_rem[i] = d_nw[i];
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, int'(req_ready_o), (1 << NR) - 1);
        check({tag, "_cmd"}, int'(cmd_valid_o), 0);
        check({tag, "_issued"}, int'(issued_o), 0);
        check({tag, "_vreq"}, int'(vrf_req_o), 0);
        check({tag, "_idx"}, int'(vrf_idx_o), 0);
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_err"}, int'(err_o), 0);
    endtask

    task automatic do_reset(input bit drained);
        #3;
        if (drained) begin
            check("cmd_q_drained", cmd_q.size(), 0);
            check("issue_q_drained", issue_q.size(), 0);
        end
        rst_ni = 1'b0;
        idle_drive();
        model_reset();
        #1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        clear_obs();
    endtask

    // Monitor: one status record per stepped cycle; command and issue events popped on appearance.
    initial begin
        stat_t exp_s, act_s;
        forever begin
            @(negedge clk_i);
            #3;
            cyc++;
            if (rst_ni && stat_q.size() > 0) begin
                exp_s = stat_q.pop_front();
                act_s = '{ready: req_ready_o, busy: busy_o, vreq: vrf_req_o,
                          idx: vrf_idx_o, err: err_o};
                total++;
                if (act_s !== exp_s) begin
                    bad++;
                    $display("FAIL status: got ready=%b busy=%b vreq=%b idx=%0d err=%b expected ready=%b busy=%b vreq=%b idx=%0d err=%b",
                             act_s.ready, act_s.busy, act_s.vreq, act_s.idx, act_s.err,
                             exp_s.ready, exp_s.busy, exp_s.vreq, exp_s.idx, exp_s.err);
                end
                if (cmd_valid_o != '0) begin
                    obs_cmd++; cmd_cyc = cyc;
                    if (cmd_q.size() == 0) check("cmd_unexpected", int'(cmd_valid_o), 0);
                    else check("cmd_valid", int'(cmd_valid_o), int'(cmd_q.pop_front()));
                end
                if (issued_o != '0) begin
                    for (int i = NR - 1; i >= 0; i--) if (issued_o[i]) obs_order.push_back(i);
                    obs_cyc.push_back(cyc);
                    if (issue_q.size() == 0) check("issue_unexpected", int'(issued_o), 0);
                    else check("issued", int'(issued_o), 1 << issue_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_idx[$];
        rst_ni = 1'b0;
        idle_drive();
        req_valid_i = '0; req_nwords_i = '0; vrf_gnt_i = 1'b0; pop_i = '0;
        model_reset();
        clear_obs();
        #2;
        check_reset_outputs("por");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NR; i++) begin
                d_valid[i] = ($urandom_range(0, 9) < 3);
                d_nw[i]    = $urandom_range(0, 5);
                d_pop[i]   = (m_used[i] > 0) && ($urandom_range(0, 1) == 1);
            end
            d_gnt = ($urandom_range(0, 3) != 0);
            step();
        end
        d_valid = '0; d_gnt = 1'b1;
        for (int c = 0; c < 100; c++) begin
            for (int i = 0; i < NR; i++) d_pop[i] = (m_used[i] > 0);
            step();
        end
        #2;
        check("rand_drain_busy", int'(busy_o), 0);
        do_reset(1);

        // Three words, grant always, pop after every issue
        d_valid = 4'b0001; d_nw[0] = 3; d_gnt = 1'b1;
        step();
        d_valid = '0;
        for (int c = 0; c < 7; c++) begin
            d_pop[0] = (m_used[0] > 0);
            step();
        end
        #2;
        check("seq3_cmd_pulses", obs_cmd, 1);
        check("seq3_issue_count", obs_order.size(), 3);
        if (obs_order.size() == 3) begin
            check("seq3_first_after_cmd", obs_cyc[0] - cmd_cyc, 1);
            check("seq3_consecutive", obs_cyc[2] - obs_cyc[0], 2);
        end
        check("seq3_idle", int'(req_ready_o[0]), 1);
        do_reset(1);

        // Credit limit: five words, no pops
        d_valid = 4'b0001; d_nw[0] = 5; d_gnt = 1'b1;
        step();
        d_valid = '0;
        for (int c = 0; c < 8; c++) step();
        #2;
        check("credit_stall_issues", obs_order.size(), 2);
        d_pop = 4'b0001;
        step();
        d_pop = '0;
        for (int c = 0; c < 4; c++) step();
        #2;
        check("credit_one_more", obs_order.size(), 3);
        do_reset(0);

        // Round-robin order with requesters 0, 1, 3
        d_valid = 4'b1011; d_nw[0] = 2; d_nw[1] = 2; d_nw[3] = 2; d_gnt = 1'b1;
        step();
        d_valid = '0;
        for (int c = 0; c < 9; c++) step();
        #2;
        check("rr_count", obs_order.size(), 6);
        if (obs_order.size() == 6) begin
            check("rr_0", obs_order[0], 0); check("rr_1", obs_order[1], 1);
            check("rr_2", obs_order[2], 3); check("rr_3", obs_order[3], 0);
            check("rr_4", obs_order[4], 1); check("rr_5", obs_order[5], 3);
        end
        do_reset(0);

        // Grant held low while eligible
        d_valid = 4'b0011; d_nw[0] = 3; d_nw[1] = 3; d_gnt = 1'b0;
        step();
        d_valid = '0;
        step();
        seen_idx.delete();
        for (int c = 0; c < 4; c++) begin
            step();
            #2;
            check("nogrant_vreq", int'(vrf_req_o), 1);
            seen_idx.push_back(int'(vrf_idx_o));
        end
        foreach (seen_idx[k]) check("nogrant_idx_stable", seen_idx[k], 0);
        check("nogrant_no_issue", obs_order.size(), 0);
        d_gnt = 1'b1;
        step(); step();
        #2;
        check("nogrant_rr_kept", (obs_order.size() > 0) ? obs_order[0] : -1, 0);
        check("nogrant_rr_next", (obs_order.size() > 1) ? obs_order[1] : -1, 1);
        do_reset(0);

        // Zero-word command
        d_valid = 4'b0001; d_nw[0] = 0; d_gnt = 1'b1;
        step();
        d_valid = '0;
        step();
        #2;
        check("zero_ready_cmd_cycle", int'(req_ready_o[0]), 0);
        step();
        #2;
        check("zero_ready_after_2", int'(req_ready_o[0]), 1);
        step(); step();
        #2;
        check("zero_cmd_pulses", obs_cmd, 1);
        check("zero_no_issue", obs_order.size(), 0);
        do_reset(1);

        // Underflow pop, then reset while issuing
        d_pop = 4'b0100;
        step();
        d_pop = '0;
        step();
        #2;
        check("err_set", int'(err_o), 1);
        step(); step();
        #2;
        check("err_sticky", int'(err_o), 1);
        d_valid = 4'b0010; d_nw[1] = 4; d_gnt = 1'b0;
        step();
        d_valid = '0;
        step(); step();
        #2;
        check("pre_reset_busy", int'(busy_o), 1);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midreset");
        idle_drive();
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        clear_obs();
        step(); step();
        #2;
        check("post_reset_err", int'(err_o), 0);
        check("post_reset_busy", int'(busy_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
